// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// and presents the registered difference and final borrow with a one-cycle done pulse.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH:0]   res_ext;

   // One full-subtractor step on the current LSBs.
   assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
   assign br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
   // New bit enters at the MSB; the extended vector keeps WIDTH=1 legal.
   assign res_ext = {d_bit, res_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               res_d   = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_ext[WIDTH:1];
            br_d  = br_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               diff_d  = res_ext[WIDTH:1];
               bout_d  = br_nxt;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign diff       = diff_q;
   assign borrow_out = bout_q;
   assign busy       = (state_q == S_SHIFT);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1: the driver queues
// expected results with their due cycle, per-width monitors pop them on done.
module tb_serial_subtractor;

   typedef struct packed {
      logic [7:0]  d;
      logic        br;
      logic [31:0] due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0, start1 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, diff8;
   logic [0:0] a1 = '0, b1 = '0, diff1;
   logic       bout8, busy8, done8, bout1, busy1, done1;

   logic [31:0] cyc = '0;
   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        q8[$];
   exp_t        q1[$];

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .diff(diff8), .borrow_out(bout8), .busy(busy8), .done(done8)
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .diff(diff1), .borrow_out(bout1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitors: every done pulse must match the oldest queued result, on its due cycle.
   always @(negedge clk) begin
      exp_t e;
      if (done8 === 1'b1) begin
         if (q8.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL w8_unexpected_done diff=%0d borrow=%0d cycle=%0d", diff8, bout8, cyc);
         end else begin
            e = q8.pop_front();
            chk("w8_diff", {24'd0, diff8}, {24'd0, e.d});
            chk("w8_borrow", {31'd0, bout8}, {31'd0, e.br});
            chk("w8_done_cycle", cyc, e.due);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL w1_unexpected_done diff=%0d borrow=%0d cycle=%0d", diff1, bout1, cyc);
         end else begin
            e = q1.pop_front();
            chk("w1_diff", {31'd0, diff1}, {24'd0, e.d});
            chk("w1_borrow", {31'd0, bout1}, {31'd0, e.br});
            chk("w1_done_cycle", cyc, e.due);
         end
      end
   end

   // Drive at a negedge; start is sampled at the next edge, done due WIDTH edges later.
   task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] dexp,
                          input logic brexp);
      a8 = av;
      b8 = bv;
      start8 = 1'b1;
      q8.push_back('{d: dexp, br: brexp, due: cyc + 32'd9});
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic finish8(output int bc);
      bc = 0;
      for (int i = 0; i < 40; i++) begin
         if (done8 === 1'b1) return;
         if (busy8 === 1'b1) bc++;
         @(negedge clk);
      end
      n_chk++;
      n_fail++;
      $display("FAIL w8_done_timeout waited=40 cycles");
   endtask

   task automatic op1(input logic av, input logic bv);
      a1 = av;
      b1 = bv;
      start1 = 1'b1;
      q1.push_back('{d: {7'd0, av ^ bv}, br: (~av & bv), due: cyc + 32'd2});
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done1 === 1'b1) break;
         @(negedge clk);
         if (i == 9) begin
            n_chk++;
            n_fail++;
            $display("FAIL w1_done_timeout waited=10 cycles");
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      logic [7:0] ra, rb;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_diff8", {24'd0, diff8}, 32'd0);
      chk("rst_borrow8", {31'd0, bout8}, 32'd0);
      chk("rst_busy8", {31'd0, busy8}, 32'd0);
      chk("rst_done8", {31'd0, done8}, 32'd0);
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      chk("rst_done1", {31'd0, done1}, 32'd0);

      // Start on the very first edge after reset: 100 - 37 = 63
      rst = 1'b0;
      launch8(8'd100, 8'd37, 8'd63, 1'b0);
      finish8(bc);
      chk("busy_cycles_100_37", bc, 32'd8);
      @(negedge clk);

      // Directed corner operands
      launch8(8'd0, 8'd0, 8'd0, 1'b0);     finish8(bc); @(negedge clk);
      launch8(8'd255, 8'd255, 8'd0, 1'b0); finish8(bc); @(negedge clk);
      launch8(8'd0, 8'd1, 8'd255, 1'b1);   finish8(bc); @(negedge clk);
      launch8(8'd5, 8'd9, 8'd252, 1'b1);   finish8(bc); @(negedge clk);
      chk("hold_diff_idle", {24'd0, diff8}, 32'd252);
      chk("hold_borrow_idle", {31'd0, bout8}, 32'd1);

      // Reset on the 4th SHIFT edge aborts silently
      a8 = 8'd20;
      b8 = 8'd3;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy8}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy8}, 32'd0);
      chk("abort_done", {31'd0, done8}, 32'd0);
      chk("abort_diff", {24'd0, diff8}, 32'd0);
      chk("abort_borrow", {31'd0, bout8}, 32'd0);
      repeat (15) @(negedge clk);

      // start held and operands changed mid-operation: captured 77 - 12 = 65, one done only
      a8 = 8'd77;
      b8 = 8'd12;
      start8 = 1'b1;
      q8.push_back('{d: 8'd65, br: 1'b0, due: cyc + 32'd9});
      repeat (3) @(negedge clk);
      a8 = 8'd3;
      b8 = 8'd250;
      @(negedge clk);
      start8 = 1'b0;
      finish8(bc);
      repeat (12) @(negedge clk);

      // Back-to-back: start in the DONE cycle of 10 - 3
      launch8(8'd10, 8'd3, 8'd7, 1'b0);
      finish8(bc);
      launch8(8'd200, 8'd1, 8'd199, 1'b0);
      chk("b2b_busy_immediate", {31'd0, busy8}, 32'd1);
      chk("b2b_diff_holds", {24'd0, diff8}, 32'd7);
      finish8(bc);
      chk("b2b_busy_cycles", bc, 32'd8);
      @(negedge clk);

      // Random sweep, WIDTH=8
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         launch8(ra, rb, ra - rb, (ra < rb));
         finish8(bc);
         @(negedge clk);
      end

      // WIDTH=1: directed then random
      op1(1'b0, 1'b0);
      op1(1'b0, 1'b1);
      op1(1'b1, 1'b0);
      op1(1'b1, 1'b1);
      for (int i = 0; i < 1000; i++) begin
         op1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      chk("w8_queue_drained", q8.size(), 32'd0);
      chk("w1_queue_drained", q1.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand width in bits; the legal range is WIDTH >= 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to compute a - b.
REQ-005 The block SHALL have port a, input, WIDTH bits: the unsigned minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits: the unsigned subtrahend.
REQ-007 The block SHALL have port diff, output, WIDTH bits: the registered result, a - b mod 2^WIDTH.
REQ-008 The block SHALL have port borrow_out, output, 1 bit: the final borrow, which is 1 iff a < b (unsigned).
REQ-009 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse that is high when diff and borrow_out are newly valid.

Function
REQ-011 The block SHALL implement an FSM with exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL capture a and b into internal shift registers, clear the borrow flop, clear the bit counter, and enter SHIFT.
REQ-013 In IDLE with start=0, the FSM SHALL remain in IDLE; in DONE with start=0, the FSM SHALL move to IDLE.
REQ-014 In SHIFT, start SHALL be ignored; a and b changing while in SHIFT SHALL NOT affect the result.
REQ-015 Each SHIFT edge SHALL process one bit, LSB first, as a full-subtractor step: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 Each SHIFT edge SHALL shift d into the MSB of an internal result shift register and shift the operand registers right by one.
REQ-017 After exactly WIDTH SHIFT edges, the FSM SHALL load diff from the result shift register and borrow_out from br_next, then enter DONE.
REQ-018 Latency: with start sampled at edge n, done SHALL be 1 in the cycle after edge n+WIDTH and 0 at every other time.
REQ-019 busy SHALL be 1 exactly while the state is SHIFT.
REQ-020 diff and borrow_out SHALL change only on the transition into DONE, or on reset, and SHALL hold their values otherwise, including through the next operation.
REQ-021 A start in the DONE cycle SHALL begin a new operation with no idle gap; done SHALL still pulse for the prior result in that same cycle.
REQ-022 For WIDTH=1, the block SHALL make exactly one SHIFT edge, and done SHALL be high in the cycle after edge n+1.
REQ-023 The bit counter SHALL be wide enough to hold WIDTH and SHALL NOT wrap within an operation.

Reset
REQ-024 rst=1 at a rising edge SHALL force the state to IDLE, clear the internal registers and counter, and set diff=0, borrow_out=0, busy=0 and done=0.
REQ-025 rst SHALL take priority over start and over any in-progress SHIFT; an interrupted operation SHALL produce no done pulse.
REQ-026 The block SHALL accept a start on the first edge after rst deasserts.

Verification
REQ-027 The bench SHALL cover: WIDTH=8, a=100, b=37, start for 1 cycle -> busy high for 8 cycles, then done=1 with diff=63 and borrow_out=0.
REQ-028 The bench SHALL cover: a=5, b=9 -> diff=252 (0xFC) and borrow_out=1; a=0, b=0 -> diff=0 and borrow_out=0; a=255, b=255 -> diff=0 and borrow_out=0; a=0, b=1 -> diff=255 and borrow_out=1.
REQ-029 The bench SHALL cover: start held high and a/b changed mid-SHIFT -> exactly one done pulse, with the result from the originally captured operands.
REQ-030 The bench SHALL cover: rst asserted at the 4th SHIFT edge -> next cycle busy=0, done=0, diff=0, borrow_out=0, and no done pulse afterwards.
REQ-031 The bench SHALL cover: start asserted in the DONE cycle with a=200, b=1 -> prior result pulsed, then busy immediately, then done after 8 cycles with diff=199.
REQ-032 The bench SHALL cover: a randomized sweep of 1000 operand pairs at WIDTH=8 and WIDTH=1, checking against {borrow_out, diff} = {a < b, (a - b) mod 2^WIDTH}.
